// File: rtl/led_pattern_counter.sv
// LED pattern counter: binary up/down, Gray-code up or single-LED bounce, advanced by a prescaled step.
// Latency: one edge from a step or LOAD to OUT/TICK/WRAP; all outputs are registered.
// Backpressure: none; EN=0 freezes the prescaler and pattern, and LOAD acts regardless of EN.
//
// Ports:
//   CLK, RST       clock (rising edge), asynchronous active-high reset
//   EN             prescaler run enable
//   MODE           00 bin up, 01 bin down, 10 Gray up, 11 bounce
//   LOAD/LOAD_VAL  synchronous load of the pattern state
//   OUT            LED drive
//   TICK           one-cycle pulse when OUT takes a new step value
//   WRAP           pulse with TICK when the step wrapped (count) or turned (bounce)
module led_pattern_counter #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] OUT,
  output logic             TICK,
  output logic             WRAP
);

  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int POSW = $clog2(WIDTH);
  localparam logic [PW-1:0]    P_LAST   = PW'(DIV - 1);
  localparam logic [POSW-1:0]  POS_LAST = POSW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [POSW-1:0]  pos_q, pos_d;
  logic             dir_q, dir_d;   // 0 = moving towards the MSB
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  logic [POSW-1:0]  pos_nxt;
  logic             dir_nxt, turn;

  // Next bounce position; the direction flips on the step that lands on an
  // end, so the end LEDs are shown exactly once per sweep.
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    cnt_dec = cnt_q - 1'b1;
    pos_nxt = pos_q;
    dir_nxt = dir_q;
    turn    = 1'b0;
    if (!dir_q) begin
      pos_nxt = pos_q + 1'b1;
      if (pos_nxt == POS_LAST) begin
        dir_nxt = 1'b1;
        turn    = 1'b1;
      end
    end else begin
      pos_nxt = pos_q - 1'b1;
      if (pos_nxt == '0) begin
        dir_nxt = 1'b0;
        turn    = 1'b1;
      end
    end
  end

  always_comb begin
    p_d    = p_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    out_d  = out_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (LOAD) begin
      cnt_d = LOAD_VAL;
      p_d   = '0;
      pos_d = '0;
      dir_d = 1'b0;
      case (MODE)
        2'b10:   out_d = LOAD_VAL ^ (LOAD_VAL >> 1);
        2'b11:   out_d = ONE_HOT0;
        default: out_d = LOAD_VAL;
      endcase
    end else if (EN) begin
      if (p_q == P_LAST) begin
        p_d    = '0;
        tick_d = 1'b1;
        case (MODE)
          2'b00: begin
            cnt_d  = cnt_inc;
            out_d  = cnt_inc;
            wrap_d = (cnt_q == ALL_ONES);
          end
          2'b01: begin
            cnt_d  = cnt_dec;
            out_d  = cnt_dec;
            wrap_d = (cnt_q == '0);
          end
          2'b10: begin
            cnt_d  = cnt_inc;
            out_d  = cnt_inc ^ (cnt_inc >> 1);
            wrap_d = (cnt_q == ALL_ONES);
          end
          default: begin
            pos_d  = pos_nxt;
            dir_d  = dir_nxt;
            out_d  = ONE_HOT0 << pos_nxt;
            wrap_d = turn;
          end
        endcase
      end else begin
        p_d = p_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      p_q    <= '0;
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      out_q  <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign OUT  = out_q;
  assign TICK = tick_q;
  assign WRAP = wrap_q;

endmodule
